tdc_result_link: RTL and testbench

Downstream stage of the TDC measurement core. Captures each completed measurement word on the TDC `done` pulse and tags it with an 8-bit sequence number. Buffers tagged words in a FIFO and serialises them as framed bytes over a valid/ready byte stream toward the host UART transmitter. Absorbs measurement bursts and flags data loss explicitly.

---
 rtl/tdc_result_link_pkg.sv | 24 ++
 rtl/tdc_sync_fifo.sv | 57 +++++
 rtl/tdc_result_link.sv | 127 ++++++++++++
 tb/tb_tdc_result_link.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_result_link_pkg.sv
// Shared constants and types for the TDC result link.
//   LINK_HEADER  : frame sync byte
//   LINK_DEPTH   : default FIFO depth
//   LINK_DATA_W  : default measurement word width
//   link_state_e : serialiser state encoding
//   link_nbytes  : data bytes per frame for a given word width
package tdc_result_link_pkg;

  localparam logic [7:0] LINK_HEADER = 8'hA5;
  localparam int         LINK_DEPTH  = 16;
  localparam int         LINK_DATA_W = 24;

  typedef enum logic [1:0] {
    LINK_IDLE = 2'd0,
    LINK_HDR  = 2'd1,
    LINK_SEQ  = 2'd2,
    LINK_DATA = 2'd3
  } link_state_e;

  function automatic int link_nbytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Single-clock FIFO, DEPTH x W bits, synchronous active-low reset.
//   clk, rst_n   : clock / reset
//   push, wdata  : write; accepted when not full, or when full with a pop
//   pop, rdata   : read; rdata is the head entry (valid while !empty)
//   full, empty  : status
//   count        : occupancy, 0..DEPTH
module tdc_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Guard locally so a stray pop/push can never corrupt the pointers.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/tdc_result_link.sv
// Captures TDC measurement words, tags them with an 8-bit sequence number,
// queues them and streams framed bytes: HEADER, SEQ, data bytes MSB first.
//   clk, iRst            : clock / synchronous active-low reset
//   iData, iValid        : measurement word and one-cycle capture strobe
//   oByte, oByteValid    : registered byte stream out
//   iByteReady           : sink accepts the current byte
//   oOverflow            : sticky, a measurement was dropped
//   oCount               : FIFO occupancy (excludes the frame being sent)
module tdc_result_link
  import tdc_result_link_pkg::*;
#(
  parameter int         DATA_W = LINK_DATA_W,
  parameter int         DEPTH  = LINK_DEPTH,
  parameter logic [7:0] HEADER = LINK_HEADER
) (
  input  logic                   clk,
  input  logic                   iRst,
  input  logic [DATA_W-1:0]      iData,
  input  logic                   iValid,
  output logic [7:0]             oByte,
  output logic                   oByteValid,
  input  logic                   iByteReady,
  output logic                   oOverflow,
  output logic [$clog2(DEPTH):0] oCount
);

  localparam int NB = link_nbytes(DATA_W);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef struct packed {
    logic [7:0]        seq;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             wr_entry, rd_entry, frame_q;
  logic               fifo_full, fifo_empty;
  logic               push, pop, drop, accept;
  logic [7:0]         seq_q;
  link_state_e        state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         byte_d;
  logic               bvld_d;
  logic [NB-1:0][7:0] data_bytes;

  assign accept   = oByteValid && iByteReady;
  assign pop      = (state_q == LINK_IDLE) && !fifo_empty;
  // A full FIFO still takes the word when the serialiser pops the same cycle.
  assign push     = iValid && (!fifo_full || pop);
  assign drop     = iValid && fifo_full && !pop;
  assign wr_entry = '{seq: seq_q, data: iData};
  assign data_bytes = (NB*8)'(frame_q.data);

  tdc_sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (iRst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (oCount)
  );

  // State register; outputs are registered from the next-state decode so
  // iByteReady never reaches oByte/oByteValid combinationally.
  always_ff @(posedge clk) begin
    if (!iRst) begin
      state_q    <= LINK_IDLE;
      idx_q      <= '0;
      oByte      <= '0;
      oByteValid <= 1'b0;
      seq_q      <= '0;
      oOverflow  <= 1'b0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      oByte      <= byte_d;
      oByteValid <= bvld_d;
      if (pop)    frame_q   <= rd_entry;
      // Dropped strobes consume a sequence number so the host sees the gap.
      if (iValid) seq_q     <= seq_q + 8'd1;
      if (drop)   oOverflow <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      LINK_IDLE: if (!fifo_empty) state_d = LINK_HDR;
      LINK_HDR:  if (accept) state_d = LINK_SEQ;
      LINK_SEQ: begin
        if (accept) begin
          state_d = LINK_DATA;
          idx_d   = IW'(NB - 1);
        end
      end
      LINK_DATA: begin
        if (accept) begin
          if (idx_q == '0) state_d = LINK_IDLE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = LINK_IDLE;
    endcase
  end

  // Output decode of the next state. frame_q is already loaded by the time
  // SEQ/DATA are entered, since it is captured on the IDLE->HDR pop.
  always_comb begin
    byte_d = '0;
    bvld_d = 1'b0;
    case (state_d)
      LINK_HDR:  begin byte_d = HEADER;            bvld_d = 1'b1; end
      LINK_SEQ:  begin byte_d = frame_q.seq;       bvld_d = 1'b1; end
      LINK_DATA: begin byte_d = data_bytes[idx_d]; bvld_d = 1'b1; end
      default:   begin byte_d = '0;                bvld_d = 1'b0; end
    endcase
  end

endmodule

// File: tb/tb_tdc_result_link.sv
module tb_tdc_result_link;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              iRst = 1'b0;
  logic [DATA_W-1:0] iData = '0;
  logic              iValid = 1'b0;
  logic [7:0]        oByte;
  logic              oByteValid;
  logic              iByteReady = 1'b1;
  logic              oOverflow;
  logic [4:0]        oCount;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [7:0] tb_seq = 8'd0;
  bit         mon_en = 1'b0;
  int         rx_cnt = 0;
  bit         hold = 1'b0;
  logic [7:0] hold_byte = 8'd0;

  tdc_result_link #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HEADER(8'hA5)) dut (
    .clk        (clk),
    .iRst       (iRst),
    .iData      (iData),
    .iValid     (iValid),
    .oByte      (oByte),
    .oByteValid (oByteValid),
    .iByteReady (iByteReady),
    .oOverflow  (oOverflow),
    .oCount     (oCount)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: sampled at negedge, where the values shown are the
  // ones the next rising edge will act on.
  always @(negedge clk) begin
    if (!mon_en) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        checks++;
        if (oByteValid !== 1'b1 || oByte !== hold_byte) begin
          errors++;
          $display("FAIL hold_stable: got vld=%b byte=%h, need vld=1 byte=%h",
                   oByteValid, oByte, hold_byte);
        end
      end
      if (oByteValid === 1'b1 && iByteReady) begin
        rx_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h, need none", oByte);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          if (oByte !== exp) begin
            errors++;
            $display("FAIL stream_byte: got %h, need %h", oByte, exp);
          end
        end
      end
      hold      = (oByteValid === 1'b1) && !iByteReady;
      hold_byte = oByte;
    end
  end

  task automatic push_frame(input logic [7:0] s, input logic [DATA_W-1:0] d);
    sb.push_back(8'hA5);
    sb.push_back(s);
    sb.push_back(d[23:16]);
    sb.push_back(d[15:8]);
    sb.push_back(d[7:0]);
  endtask

  // One-cycle strobe; keep=1 means the word is expected to reach the stream.
  task automatic strobe(input logic [DATA_W-1:0] d, input bit keep);
    iData  = d;
    iValid = 1'b1;
    if (keep) push_frame(tb_seq, d);
    tb_seq = tb_seq + 8'd1;
    @(posedge clk); #1;
    iValid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    iRst   = 1'b0;
    iValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    iRst = 1'b1;
    sb.delete();
    tb_seq = 8'd0;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    iRst = 1'b0;
    iValid = 1'b1;
    iData = 24'hDEAD01;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (oByteValid !== 1'b0 || oByte !== 8'h00 || oOverflow !== 1'b0 || oCount !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: got vld=%b byte=%h ovf=%b cnt=%0d, need 0/00/0/0",
               oByteValid, oByte, oOverflow, oCount);
    end
    iValid = 1'b0;
    iRst   = 1'b1;
    tb_seq = 8'd0;
    sb.delete();
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (oCount !== 5'd0 || oByteValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_valid: got cnt=%0d vld=%b, need 0/0", oCount, oByteValid);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp [5];
    exp = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34};
    iByteReady = 1'b1;
    strobe(24'h001234, 1'b1);   // now at t+1
    checks++;
    if (oCount !== 5'd1 || oByteValid !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: got cnt=%0d vld=%b, need 1/0", oCount, oByteValid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (oByteValid !== 1'b1 || oByte !== exp[i]) begin
        errors++;
        $display("FAIL single_byte%0d: got vld=%b byte=%h, need 1/%h", i, oByteValid, oByte, exp[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (oByteValid !== 1'b0 || oCount !== 5'd0) begin
      errors++;
      $display("FAIL single_end: got vld=%b cnt=%0d, need 0/0", oByteValid, oCount);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    iByteReady = 1'b0;
    strobe(24'h001234, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      iByteReady = 1'($urandom_range(0, 1));
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    iByteReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || oByteValid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: got left=%0d vld=%b, need 0/0", sb.size(), oByteValid);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    iByteReady = 1'b0;
    // First word goes to the serialiser, next 16 fill the FIFO, the 18th drops.
    for (int i = 0; i < 18; i++) strobe(24'(32'h00A000 + i), (i < 17));
    checks++;
    if (oCount !== 5'd16 || oOverflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_fill: got cnt=%0d ovf=%b, need 16/1", oCount, oOverflow);
    end
    iByteReady = 1'b1;
    wait_drain(400, ok);
    checks++;
    if (!ok || oCount !== 5'd0) begin
      errors++;
      $display("FAIL overflow_drain: got left=%0d cnt=%0d, need 0/0", sb.size(), oCount);
    end
    checks++;
    if (tb_seq !== 8'h12) begin
      errors++;
      $display("FAIL overflow_seq_model: got %h, need 12", tb_seq);
    end
    strobe(24'hABCDEF, 1'b1);
    wait_drain(50, ok);
    checks++;
    if (!ok || oOverflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got left=%0d ovf=%b, need 0/1", sb.size(), oOverflow);
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    bit idle_seen;
    do_reset();
    iByteReady = 1'b0;
    for (int i = 0; i < 17; i++) strobe(24'(32'h00B000 + i), 1'b1);
    checks++;
    if (oCount !== 5'd16 || oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_fill: got cnt=%0d ovf=%b, need 16/0", oCount, oOverflow);
    end
    iByteReady = 1'b1;
    idle_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (oByteValid === 1'b0) begin idle_seen = 1'b1; break; end
    end
    checks++;
    if (!idle_seen) begin
      errors++;
      $display("FAIL fullpop_idle: got no idle cycle, need one within 20");
    end
    strobe(24'h5A5A5A, 1'b1);
    checks++;
    if (oCount !== 5'd16 || oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_accept: got cnt=%0d ovf=%b, need 16/0", oCount, oOverflow);
    end
    wait_drain(400, ok);
    checks++;
    if (!ok || oCount !== 5'd0) begin
      errors++;
      $display("FAIL fullpop_drain: got left=%0d cnt=%0d, need 0/0", sb.size(), oCount);
    end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    int fails;
    do_reset();
    iByteReady = 1'b1;
    fails = 0;
    for (int i = 0; i < 257; i++) begin
      strobe(24'($urandom), 1'b1);
      wait_drain(30, ok);
      if (!ok) fails++;
    end
    checks++;
    if (fails != 0 || tb_seq !== 8'h01) begin
      errors++;
      $display("FAIL seq_wrap: got timeouts=%0d seq=%h, need 0/01", fails, tb_seq);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rx0;
    do_reset();
    iByteReady = 1'b1;
    strobe(24'h111111, 1'b1);
    strobe(24'h222222, 1'b1);
    @(posedge clk); #1;       // SEQ byte of first frame on the bus
    checks++;
    if (oByteValid !== 1'b1 || oByte !== 8'h00 || oCount !== 5'd1) begin
      errors++;
      $display("FAIL midreset_pre: got vld=%b byte=%h cnt=%0d, need 1/00/1", oByteValid, oByte, oCount);
    end
    mon_en = 1'b0;
    iRst   = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (oByteValid !== 1'b0 || oCount !== 5'd0 || oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_post: got vld=%b cnt=%0d ovf=%b, need 0/0/0", oByteValid, oCount, oOverflow);
    end
    iRst = 1'b1;
    sb.delete();
    tb_seq = 8'd0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (oByteValid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abandon: got vld=%b, need 0", oByteValid);
    end
    rx0 = rx_cnt;
    strobe(24'h0C0FFE, 1'b1);
    wait_drain(50, ok);
    checks++;
    if (!ok || (rx_cnt - rx0) != 5) begin
      errors++;
      $display("FAIL midreset_frame: got left=%0d bytes=%0d, need 0/5", sb.size(), rx_cnt - rx0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_seq_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
